accumw_term_count: RTL and testbench
====================================

ACCUMW_TERM_COUNT -- requirements
Module: accumw_term_count

Interface
REQ-001 Parameters SHALL be: inwidth, default 8, width of product input i0.
REQ-002 Parameters SHALL be: outwidth, default 16, width of accumulator and o0; outwidth >= inwidth.
REQ-003 Parameters SHALL be: numterms, default 4, products summed per result; numterms >= 1.
REQ-004 Parameters SHALL be: satmode, default 0, 0 = wrap modulo 2^outwidth, 1 = clamp to all-ones.
REQ-005 Ports SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-006 Ports SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-007 Ports SHALL be: flush  input  1  synchronous clear of in-flight accumulation.
REQ-008 Ports SHALL be: enable  input  1  pipeline advance; all state holds when 0.
REQ-009 Ports SHALL be: pred  input  1  i0 valid; driven by upstream multiplier o0_enable.
REQ-010 Ports SHALL be: last  input  1  qualifies pred; forces early completion of current group.
REQ-011 Ports SHALL be: i0  input  inwidth  unsigned product from upstream multiplier o0.
REQ-012 Ports SHALL be: o0_enable  output  1  result valid, registered.
REQ-013 Ports SHALL be: o0  output  outwidth  completed sum, registered.
REQ-014 Ports SHALL be: o0_ovf  output  1  overflow occurred within the group reported on o0.

Function
REQ-015 An accepted term SHALL be a cycle with enable=1, flush=0, pred=1; i0 zero-extended to outwidth.
REQ-016 State SHALL be: acc (outwidth), cnt (0..numterms-1), ovf_acc (1), o0, o0_ovf, o0_enable.
REQ-017 Completion SHALL occur on an accepted term with cnt==numterms-1 or last=1.
REQ-018 On accepted non-completing term: acc <= sum, cnt <= cnt+1, ovf_acc <= ovf_acc | carry.
REQ-019 On completion: o0 <= sum, o0_ovf <= ovf_acc | carry, acc <= 0, cnt <= 0, ovf_acc <= 0.
REQ-020 sum SHALL be acc+i0 in outwidth bits; carry = bit outwidth of the full sum.
REQ-021 satmode=1 with carry, or ovf_acc already set: sum SHALL be all-ones; satmode=0: sum wraps.
REQ-022 o0_enable SHALL be updated only when enable=1: set to 1 if the cycle completes, else 0.
REQ-023 Latency SHALL be exactly one enabled clock from completing term to o0_enable=1 with valid o0.
REQ-024 enable=0 SHALL hold every register, including o0_enable, regardless of pred/last.
REQ-025 pred=0 with enable=1 SHALL leave acc/cnt unchanged and clear o0_enable; last ignored.
REQ-026 flush=1 SHALL clear acc, cnt, ovf_acc, o0_enable irrespective of enable; o0, o0_ovf hold.
REQ-027 flush SHALL take priority over a simultaneous accepted term; that term is discarded.
REQ-028 numterms=1 SHALL complete on every accepted term (back-to-back o0_enable).
REQ-029 last=1 with cnt==numterms-1 SHALL produce one completion only.
REQ-030 o0 SHALL retain the last result until the next completion.

Reset
REQ-031 reset=0 SHALL asynchronously clear acc, cnt, ovf_acc, o0, o0_ovf, o0_enable to 0.
REQ-032 Reset mid-group SHALL discard partial sum; first accepted term after release starts at cnt=0.
REQ-033 Deassertion SHALL be taken synchronously to clk by the integrating level; no internal synchroniser.

Structure
REQ-034 Shared package SHALL hold the count-width function (clog2 of numterms, minimum 1) and satmode encodings.
REQ-035 One sub-module SHALL be used: accumw_term_counter (cnt register, terminal-count compare, flush/enable/reset handling).
REQ-036 Adder, saturation and output registers SHALL live in the top module.

Verification
REQ-037 numterms=4, i0=1,2,3,4 accepted consecutively -> o0_enable=1 one cycle later, o0=10, o0_ovf=0.
REQ-038 outwidth=8, inwidth=8, satmode=1, i0=200,100 (numterms=2) -> o0=255, o0_ovf=1; satmode=0 -> o0=44, o0_ovf=1.
REQ-039 numterms=4, i0=5,6 then 7 with last=1 -> o0=18 after third term; next group from cnt=0.
REQ-040 Stall: enable=0 for 3 cycles mid-group and during o0_enable=1 -> o0_enable stays 1 through stall, sum unchanged (1+2+3+4=10).
REQ-041 flush with pred=1 on third of four terms (i0=1,2,9) then 3,4,5,6 -> discards 1,2,9; o0=18.
REQ-042 reset pulse low after two terms -> all outputs 0 asynchronously; following 4 terms of 1 -> o0=4.

Source files
------------

// File: rtl/accumw_term_count_pkg.sv
// accumw_term_count_pkg
//   Shared definitions for the term-counting accumulator:
//   - satmode_e : encodings of the satmode parameter (wrap / clamp)
//   - cnt_width : width of the term counter for a given numterms
package accumw_term_count_pkg;

  typedef enum int unsigned {
    SAT_WRAP  = 0,  // sum wraps modulo 2^outwidth
    SAT_CLAMP = 1   // sum sticks at all-ones once any carry was seen
  } satmode_e;

  // clog2(numterms), but never narrower than one bit so numterms=1 still
  // has a legal (constant zero) counter register.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/accumw_term_counter.sv
// accumw_term_counter
//   Term counter for accumw_term_count. Tracks how many terms of the current
//   group have been accepted and flags the term that completes the group.
//   Ports:
//     clk_i       clock, all state on rising edge
//     rst_ni      asynchronous active-low reset
//     flush_i     synchronous clear (works regardless of enable_i)
//     enable_i    pipeline advance; count holds when 0
//     pred_i      term valid
//     last_i      forces completion of the current group (qualified by pred_i)
//     cnt_o       current count, 0..numterms-1
//     accept_o    this cycle accepts a term (enable & pred & !flush)
//     complete_o  the accepted term completes the group
module accumw_term_counter
  import accumw_term_count_pkg::*;
#(
  parameter int unsigned numterms = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           enable_i,
  input  logic                           pred_i,
  input  logic                           last_i,
  output logic [cnt_width(numterms)-1:0] cnt_o,
  output logic                           accept_o,
  output logic                           complete_o
);

  localparam int unsigned CW = cnt_width(numterms);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign accept_o   = enable_i & pred_i & ~flush_i;
  assign terminal   = (cnt_q == CW'(numterms - 1));
  // last on the terminal term is still a single completion.
  assign complete_o = accept_o & (terminal | last_i);
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (accept_o) begin
      cnt_d = complete_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/accumw_term_count.sv
// accumw_term_count
//   Accumulates numterms unsigned products from an upstream multiplier and
//   presents each completed group sum on a registered output, with an
//   overflow flag for the group. A group ends early on an accepted term with
//   last=1. satmode selects wrap-around or clamp-to-all-ones arithmetic.
//   Ports:
//     clk        clock, all state on rising edge
//     reset      asynchronous active-low reset
//     flush      synchronous clear of in-flight accumulation and o0_enable
//     enable     pipeline advance; all state holds when 0
//     pred       i0 valid
//     last       qualifies pred; completes the current group
//     i0         unsigned product, inwidth bits
//     o0_enable  registered result valid
//     o0         registered completed sum, outwidth bits
//     o0_ovf     overflow seen within the group reported on o0
module accumw_term_count
  import accumw_term_count_pkg::*;
#(
  parameter int unsigned inwidth  = 8,
  parameter int unsigned outwidth = 16,
  parameter int unsigned numterms = 4,
  parameter int unsigned satmode  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                enable,
  input  logic                pred,
  input  logic                last,
  input  logic [inwidth-1:0]  i0,
  output logic                o0_enable,
  output logic [outwidth-1:0] o0,
  output logic                o0_ovf
);

  localparam int unsigned CW    = cnt_width(numterms);
  localparam bit          CLAMP = (satmode == SAT_CLAMP);

  logic [outwidth-1:0] acc_q, acc_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [outwidth-1:0] o0_q, o0_d;
  logic                o0_ovf_q, o0_ovf_d;
  logic                o0_en_q, o0_en_d;

  logic [CW-1:0]       cnt;
  logic                accept;
  logic                complete;

  logic [outwidth-1:0] i0_ext;
  logic [outwidth:0]   full_sum;
  logic                carry;
  logic [outwidth-1:0] sum;

  accumw_term_counter #(
    .numterms (numterms)
  ) u_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (flush),
    .enable_i   (enable),
    .pred_i     (pred),
    .last_i     (last),
    .cnt_o      (cnt),
    .accept_o   (accept),
    .complete_o (complete)
  );

  // The count value itself is only needed inside the counter.
  logic cnt_unused;
  assign cnt_unused = ^cnt;

  always_comb begin
    i0_ext              = '0;
    i0_ext[inwidth-1:0] = i0;
  end

  assign full_sum = {1'b0, acc_q} + {1'b0, i0_ext};
  assign carry    = full_sum[outwidth];

  // In clamp mode a group that has overflowed once stays at all-ones.
  assign sum = (CLAMP && (carry || ovf_acc_q)) ? '1 : full_sum[outwidth-1:0];

  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    o0_d      = o0_q;
    o0_ovf_d  = o0_ovf_q;
    o0_en_d   = o0_en_q;
    if (flush) begin
      acc_d     = '0;
      ovf_acc_d = 1'b0;
      o0_en_d   = 1'b0;
    end else if (enable) begin
      o0_en_d = complete;
      if (complete) begin
        o0_d      = sum;
        o0_ovf_d  = ovf_acc_q | carry;
        acc_d     = '0;
        ovf_acc_d = 1'b0;
      end else if (accept) begin
        acc_d     = sum;
        ovf_acc_d = ovf_acc_q | carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      o0_q      <= '0;
      o0_ovf_q  <= 1'b0;
      o0_en_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      o0_q      <= o0_d;
      o0_ovf_q  <= o0_ovf_d;
      o0_en_q   <= o0_en_d;
    end
  end

  assign o0_enable = o0_en_q;
  assign o0        = o0_q;
  assign o0_ovf    = o0_ovf_q;

endmodule

// File: tb/tb_accumw_term_count.sv
// Bench for accumw_term_count: four instances with different parameter sets
// share one stimulus stream and are checked every cycle against a group-sum
// model that works on exact integer totals.
module tb_accumw_term_count;

  localparam int NW[4] = '{16, 8, 8, 16};  // outwidth
  localparam int NN[4] = '{4, 2, 2, 1};    // numterms
  localparam int NS[4] = '{0, 1, 0, 0};    // satmode

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       enable = 1'b0;
  logic       pred = 1'b0;
  logic       last = 1'b0;
  logic [7:0] i0 = '0;

  logic        en_0, en_1, en_2, en_3;
  logic        ov_0, ov_1, ov_2, ov_3;
  logic [15:0] o0_0, o0_3;
  logic [7:0]  o0_1, o0_2;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  accumw_term_count #(.inwidth(8), .outwidth(16), .numterms(4), .satmode(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .pred(pred),
    .last(last), .i0(i0), .o0_enable(en_0), .o0(o0_0), .o0_ovf(ov_0));
  accumw_term_count #(.inwidth(8), .outwidth(8), .numterms(2), .satmode(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .pred(pred),
    .last(last), .i0(i0), .o0_enable(en_1), .o0(o0_1), .o0_ovf(ov_1));
  accumw_term_count #(.inwidth(8), .outwidth(8), .numterms(2), .satmode(0)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .pred(pred),
    .last(last), .i0(i0), .o0_enable(en_2), .o0(o0_2), .o0_ovf(ov_2));
  accumw_term_count #(.inwidth(8), .outwidth(16), .numterms(1), .satmode(0)) u3 (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .pred(pred),
    .last(last), .i0(i0), .o0_enable(en_3), .o0(o0_3), .o0_ovf(ov_3));

  function automatic longint dut_o(input int d);
    case (d)
      0:       return longint'(o0_0);
      1:       return longint'(o0_1);
      2:       return longint'(o0_2);
      default: return longint'(o0_3);
    endcase
  endfunction

  function automatic longint dut_en(input int d);
    case (d)
      0:       return longint'(en_0);
      1:       return longint'(en_1);
      2:       return longint'(en_2);
      default: return longint'(en_3);
    endcase
  endfunction

  function automatic longint dut_ov(input int d);
    case (d)
      0:       return longint'(ov_0);
      1:       return longint'(ov_1);
      2:       return longint'(ov_2);
      default: return longint'(ov_3);
    endcase
  endfunction

  // Model: exact running total and term count of the open group; a completed
  // group reports the total reduced by the instance's overflow rule.
  longint tot[4]   = '{0, 0, 0, 0};
  int     n[4]     = '{0, 0, 0, 0};
  bit     m_en[4]  = '{0, 0, 0, 0};
  longint m_o[4]   = '{0, 0, 0, 0};
  bit     m_ovf[4] = '{0, 0, 0, 0};
  longint t, lim;

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 4; d++) begin
      if (!reset) begin
        tot[d] <= 0; n[d] <= 0; m_en[d] <= 1'b0; m_o[d] <= 0; m_ovf[d] <= 1'b0;
      end else if (flush) begin
        tot[d] <= 0; n[d] <= 0; m_en[d] <= 1'b0;
      end else if (enable) begin
        if (pred) begin
          t   = tot[d] + longint'(i0);
          lim = longint'(1) << NW[d];
          if (n[d] + 1 == NN[d] || last) begin
            m_en[d]  <= 1'b1;
            m_o[d]   <= (NS[d] == 1) ? ((t >= lim) ? lim - 1 : t) : (t % lim);
            m_ovf[d] <= (t >= lim);
            tot[d]   <= 0;
            n[d]     <= 0;
          end else begin
            tot[d]  <= t;
            n[d]    <= n[d] + 1;
            m_en[d] <= 1'b0;
          end
        end else begin
          m_en[d] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("u%0d.o0_enable", d), dut_en(d), longint'(m_en[d]));
        check($sformatf("u%0d.o0", d), dut_o(d), m_o[d]);
        check($sformatf("u%0d.o0_ovf", d), dut_ov(d), longint'(m_ovf[d]));
      end
    end
  end

  task automatic cyc(input bit e, input bit f, input bit p, input bit l, input int v);
    @(posedge clk);
    #2;
    enable = e; flush = f; pred = p; last = l; i0 = 8'(v);
  endtask

  task automatic term(input int v);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, v);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset u%0d.o0", d), dut_o(d), 0);
      check($sformatf("reset u%0d.o0_enable", d), dut_en(d), 0);
    end
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Four consecutive terms
    term(1); term(2); term(3); term(4); idle();
    @(negedge clk);
    check("sum4 en", longint'(en_0), 1);
    check("sum4 o0", longint'(o0_0), 10);
    check("sum4 ovf", longint'(ov_0), 0);
    check("sum4 model", m_o[0], 10);

    // 8-bit overflow: clamp vs wrap
    term(200); term(100); idle();
    @(negedge clk);
    check("clamp o0", longint'(o0_1), 255);
    check("clamp ovf", longint'(ov_1), 1);
    check("wrap o0", longint'(o0_2), 44);
    check("wrap ovf", longint'(ov_2), 1);
    check("wrap model", m_o[2], 44);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Early completion by last, then a fresh group
    term(5); term(6); cyc(1'b1, 1'b0, 1'b1, 1'b1, 7); idle();
    @(negedge clk);
    check("last o0", longint'(o0_0), 18);
    check("last en", longint'(en_0), 1);
    term(1); term(1); term(1); term(1); idle();
    @(negedge clk);
    check("after last o0", longint'(o0_0), 4);

    // Stalls mid-group and while the result is valid
    term(1); term(2);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 77);
    term(3); term(4);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9);
      @(negedge clk);
      check($sformatf("stall%0d en", k), longint'(en_0), 1);
      check($sformatf("stall%0d o0", k), longint'(o0_0), 10);
    end
    idle();

    // Flush beats a simultaneous term
    term(1); term(2); cyc(1'b1, 1'b1, 1'b1, 1'b0, 9);
    term(3); term(4); term(5); term(6); idle();
    @(negedge clk);
    check("flush o0", longint'(o0_0), 18);

    // Asynchronous reset mid-group
    term(1); term(1); cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #3 reset = 1'b0;
    #1;
    check("areset o0", longint'(o0_0), 0);
    check("areset en", longint'(en_0), 0);
    check("areset ovf", longint'(ov_1), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    term(1); term(1); term(1); term(1); idle();
    @(negedge clk);
    check("post reset o0", longint'(o0_0), 4);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 6, $urandom_range(0, 6) == 0,
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(200, 255))
                                      : int'($urandom_range(0, 255)));
    end
    idle(); idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
